memory_data_unit: RTL and testbench

//  Load/store data path between the operation controller and the external pads; downstream of the controller.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/load_aligner.sv | 25 ++
 rtl/memory_data_unit.sv | 157 +++++++++++++++
 tb/tb_memory_data_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, funct3 encodings and lane helpers for the memory data unit.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DONE} mem_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: lane_mask = 4'b0001 << off;
            F3_H, F3_HU: lane_mask = 4'b0011 << off;
            F3_W:        lane_mask = 4'b1111;
            default:     lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic access_legal(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: access_legal = 1'b1;
            F3_H, F3_HU: access_legal = ~off[0];
            F3_W:        access_legal = (off == 2'b00);
            default:     access_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] d);
        case (funct3)
            F3_B, F3_BU: store_lanes = {4{d[7:0]}};
            F3_H, F3_HU: store_lanes = {2{d[15:0]}};
            default:     store_lanes = d;
        endcase
    endfunction

endpackage

// File: rtl/load_aligner.sv
// load_aligner: shifts the returned pad word down to the accessed lane and sign/zero-extends it.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] result_o
);

    logic [31:0] raw;

    assign raw = data_i >> {off_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    result_o = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   result_o = {24'b0, raw[7:0]};
            F3_H:    result_o = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   result_o = {16'b0, raw[15:0]};
            default: result_o = raw;
        endcase
    end

endmodule

// File: rtl/memory_data_unit.sv
// memory_data_unit: load/store path between the operation controller and the external pads,
// with alignment checking, a bounded wait for pad_ready and extended load write-back.
module memory_data_unit
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT   = 15,
    parameter bit NOP_ON_ERROR = 1'b1
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:1]  phase,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  data_type,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [31:0] pad_data_in,
    input  logic        pad_ready,
    output logic [31:0] pad_address,
    output logic [31:0] pad_data_out,
    output logic [3:0]  pad_byte_enable,
    output logic        pad_request,
    output logic        pad_write_enable,
    output logic [31:0] load_result,
    output logic        load_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        pend_q, pend_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        ld_q;
    logic        we_q;
    logic [31:0] data_q;
    logic        issue;
    logic        legal;
    logic        accept;
    logic [31:0] aligned;
    logic [31:0] fault_val;

    assign issue     = phase[2] & (load | store);
    assign legal     = access_legal(data_type, address[1:0]);
    assign accept    = (state_q == IDLE) & issue & legal;
    assign fault_val = NOP_ON_ERROR ? 32'h0 : result_q;

    load_aligner u_aligner (
        .data_i   (pad_data_in),
        .funct3_i (f3_q),
        .off_i    (off_q),
        .result_o (aligned)
    );

    // A faulted load still owes the register file one load_valid on the next phase[1]; pend tracks that.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        pend_d   = pend_q & ~phase[1];
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue && legal) begin
                    state_d = REQUEST;
                end else if (issue) begin
                    mis_d = 1'b1;
                    if (load) begin
                        pend_d   = 1'b1;
                        result_d = fault_val;
                    end
                end
            end
            REQUEST: begin
                state_d = pad_ready ? DONE : WAIT;
                cnt_d   = pad_ready ? 4'd0 : 4'd1;
                if (pad_ready && ld_q) result_d = aligned;
            end
            WAIT: begin
                if (pad_ready) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (ld_q) result_d = aligned;
                end else if (cnt_q == 4'(WAIT_LIMIT)) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    berr_d  = 1'b1;
                    if (ld_q) begin
                        pend_d   = 1'b1;
                        result_d = fault_val;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (phase[1]) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            result_q <= 32'h0;
            pend_q   <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            pend_q   <= pend_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 30'h0;
            off_q  <= 2'b00;
            f3_q   <= 3'd0;
            ld_q   <= 1'b0;
            we_q   <= 1'b0;
            data_q <= 32'h0;
        end else if (accept) begin
            addr_q <= address[31:2];
            off_q  <= address[1:0];
            f3_q   <= data_type;
            ld_q   <= load;
            we_q   <= store & ~load;
            data_q <= store_lanes(data_type, store_data);
        end
    end

    assign pad_request      = (state_q == REQUEST) | (state_q == WAIT);
    assign pad_address      = {addr_q, 2'b00};
    assign pad_data_out     = data_q;
    assign pad_byte_enable  = pad_request ? lane_mask(f3_q, off_q) : 4'b0000;
    assign pad_write_enable = pad_request & we_q;
    assign stall            = (state_q == WAIT);
    assign load_result      = result_q;
    assign load_valid       = phase[1] & (((state_q == DONE) & ld_q) | pend_q);
    assign misaligned       = mis_q;
    assign bus_error        = berr_q;

endmodule

// File: tb/tb_memory_data_unit.sv
// tb_memory_data_unit: directed table of single accesses plus hand-written wait, timeout and reset sequences.
module tb_memory_data_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:1]  phase = 2'b00;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  data_type = 3'd0;
    logic [31:0] address = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] pad_data_in = 32'h0;
    logic        pad_ready = 1'b0;
    logic [31:0] pad_address;
    logic [31:0] pad_data_out;
    logic [3:0]  pad_byte_enable;
    logic        pad_request;
    logic        pad_write_enable;
    logic [31:0] load_result;
    logic        load_valid;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int checks = 0;
    int failures = 0;
    int vi = 0;

    memory_data_unit dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .phase            (phase),
        .load             (load),
        .store            (store),
        .data_type        (data_type),
        .address          (address),
        .store_data       (store_data),
        .pad_data_in      (pad_data_in),
        .pad_ready        (pad_ready),
        .pad_address      (pad_address),
        .pad_data_out     (pad_data_out),
        .pad_byte_enable  (pad_byte_enable),
        .pad_request      (pad_request),
        .pad_write_enable (pad_write_enable),
        .load_result      (load_result),
        .load_valid       (load_valid),
        .stall            (stall),
        .misaligned       (misaligned),
        .bus_error        (bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        logic        ok;
        logic [3:0]  be;
        logic [31:0] pdo;
        logic [31:0] res;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (case %0d) actual=%h required=%h", n, vi, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (case %0d) actual=%b required=%b", n, vi, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_addr"}, pad_address, 32'h0);
        chk({n, "_pdo"}, pad_data_out, 32'h0);
        chk({n, "_be"}, {28'h0, pad_byte_enable}, 32'h0);
        chk({n, "_res"}, load_result, 32'h0);
        chk1({n, "_req"}, pad_request, 1'b0);
        chk1({n, "_we"}, pad_write_enable, 1'b0);
        chk1({n, "_lv"}, load_valid, 1'b0);
        chk1({n, "_stall"}, stall, 1'b0);
        chk1({n, "_mis"}, misaligned, 1'b0);
        chk1({n, "_berr"}, bus_error, 1'b0);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        @(negedge clock);
        phase = 2'b10; load = ld; store = st; data_type = f3;
        address = a; store_data = sd; pad_ready = 1'b0;
        #1;
        chk1("idle_req", pad_request, 1'b0);
    endtask

    task automatic quiet(input logic [2:1] ph, input logic rdy, input logic [31:0] rd);
        @(negedge clock);
        phase = ph; load = 1'b0; store = 1'b0; pad_ready = rdy; pad_data_in = rd;
        #1;
    endtask

    // Zero-wait access: issue, REQUEST with pad_ready, DONE on phase[1], then IDLE with stray pad_ready.
    task automatic run(input vec_t t);
        issue(t.ld, t.st, t.f3, t.addr, t.sd);
        quiet(2'b00, 1'b1, t.rd);
        chk1("mis", misaligned, ~t.ok);
        chk1("req", pad_request, t.ok);
        chk("be", {28'h0, pad_byte_enable}, {28'h0, t.ok ? t.be : 4'b0000});
        chk1("we", pad_write_enable, t.ok & t.st);
        if (t.ok) chk("paddr", pad_address, {t.addr[31:2], 2'b00});
        if (t.ok && t.st) chk("pdo", pad_data_out, t.pdo);
        quiet(2'b01, 1'b0, 32'h0);
        chk1("lv", load_valid, t.ld);
        chk1("stall_done", stall, 1'b0);
        if (t.ld) chk("res", load_result, t.res);
        quiet(2'b00, 1'b1, ~t.rd);
        chk1("lv_after", load_valid, 1'b0);
        chk1("mis_after", misaligned, 1'b0);
        chk1("req_after", pad_request, 1'b0);
        if (t.ld) chk("res_hold", load_result, t.res);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int stalls;
        int err_c;
        logic berr_seen;
        v[0]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF};
        v[1]  = '{1'b1, 1'b0, 3'd0, 32'h203, 32'h0,        32'h80123456, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80};
        v[2]  = '{1'b1, 1'b0, 3'd4, 32'h203, 32'h0,        32'h80123456, 1'b1, 4'b1000, 32'h0,        32'h00000080};
        v[3]  = '{1'b0, 1'b1, 3'd1, 32'h12,  32'h1234ABCD, 32'h0,        1'b1, 4'b1100, 32'hABCDABCD, 32'h0};
        v[4]  = '{1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        32'h55555555, 1'b0, 4'b0000, 32'h0,        32'h0};
        v[5]  = '{1'b1, 1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 1'b1, 4'b1100, 32'h0,        32'hFFFF8001};
        v[6]  = '{1'b1, 1'b0, 3'd5, 32'h102, 32'h0,        32'h80017FFF, 1'b1, 4'b1100, 32'h0,        32'h00008001};
        v[7]  = '{1'b0, 1'b1, 3'd0, 32'h31,  32'h000000A5, 32'h0,        1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0};
        v[8]  = '{1'b0, 1'b1, 3'd2, 32'h44,  32'hCAFEF00D, 32'h0,        1'b1, 4'b1111, 32'hCAFEF00D, 32'h0};
        v[9]  = '{1'b1, 1'b0, 3'd0, 32'h1,   32'h0,        32'h00007F00, 1'b1, 4'b0010, 32'h0,        32'h0000007F};
        v[10] = '{1'b1, 1'b0, 3'd3, 32'h0,   32'h0,        32'h12345678, 1'b0, 4'b0000, 32'h0,        32'h0};
        v[11] = '{1'b0, 1'b1, 3'd1, 32'h3,   32'hFFFF0000, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0};
        v[12] = '{1'b1, 1'b0, 3'd1, 32'h0,   32'h0,        32'h0000C3A5, 1'b1, 4'b0011, 32'h0,        32'hFFFFC3A5};

        #3;
        chk_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            vi = i;
            run(v[i]);
        end

        // LH with pad_ready on the third WAIT cycle
        vi = 100;
        stalls = 0;
        issue(1'b1, 1'b0, 3'd1, 32'h6, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            quiet(2'b00, c == 4, 32'hFEDC0000);
            if (stall) stalls++;
        end
        chk("wait_stalls", stalls, 3);
        quiet(2'b01, 1'b0, 32'h0);
        chk1("wait_lv", load_valid, 1'b1);
        chk("wait_res", load_result, 32'hFFFFFEDC);

        // LW that never gets pad_ready: bus_error after WAIT_LIMIT cycles of stall
        vi = 101;
        stalls = 0;
        err_c = 0;
        issue(1'b1, 1'b0, 3'd2, 32'h8, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            quiet(2'b00, 1'b0, 32'h0);
            if (bus_error) begin
                err_c = c;
                break;
            end
            if (stall) stalls++;
        end
        chk("to_cycle", err_c, 17);
        chk("to_stalls", stalls, 15);
        chk1("to_req", pad_request, 1'b0);
        chk1("to_stall", stall, 1'b0);
        quiet(2'b01, 1'b0, 32'h0);
        chk1("to_lv", load_valid, 1'b1);
        chk("to_res", load_result, 32'h0);
        chk1("to_berr_once", bus_error, 1'b0);
        quiet(2'b00, 1'b0, 32'h0);

        // pad_ready on the same cycle the counter hits WAIT_LIMIT
        vi = 102;
        berr_seen = 1'b0;
        issue(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            quiet(2'b00, c == 16, 32'h000000FF);
            berr_seen = berr_seen | bus_error;
        end
        chk1("lim_berr", berr_seen, 1'b0);
        quiet(2'b01, 1'b0, 32'h0);
        chk1("lim_lv", load_valid, 1'b1);
        chk("lim_res", load_result, 32'hFFFFFFFF);

        // asynchronous reset while in WAIT, then a normal LW
        vi = 103;
        issue(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        quiet(2'b00, 1'b0, 32'h0);
        quiet(2'b00, 1'b0, 32'h0);
        chk1("rst_pre_stall", stall, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clock);
        reset_n = 1'b1;
        vi = 104;
        run('{1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h11223344, 1'b1, 4'b1111, 32'h0, 32'h11223344});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
